// File: rtl/display_scheduler.sv
// Round-robin scheduler for the four-digit display: rotates over valid 16-bit sources,
// pre-empts for a one-shot alert (only when DISP_SCHED_ALERT_EN is defined), and saturates to 0..9999.
module display_scheduler #(
  parameter int unsigned DWELL      = 4,
  parameter int unsigned ALERT_HOLD = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tick,
  input  logic [2:0]  i_src_valid,
  input  logic [15:0] i_src0_val,
  input  logic [15:0] i_src1_val,
  input  logic [15:0] i_src2_val,
  input  logic        i_alert_req,
  input  logic [15:0] i_alert_val,
  output logic        o_alert_ack,
  output logic [15:0] o_disp_value,
  output logic [1:0]  o_disp_src,
  output logic        o_disp_blank
);

  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROTATE = 2'd1;

  logic [1:0]    r_state, w_state_nx;
  logic [1:0]    r_cur, w_cur_nx;
  logic [DW-1:0] r_dwell, w_dwell_nx;
  logic          w_accept;
  logic [15:0]   w_src_sel;
  logic [15:0]   w_value_nx;
  logic [1:0]    w_src_nx;
  logic          w_blank_nx;

  function automatic logic [1:0] f_next(input logic [1:0] cur, input logic [2:0] v);
    logic [1:0] n1, n2;
    n1 = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
    n2 = (n1 == 2'd2) ? 2'd0 : n1 + 2'd1;
    if (v[n1])      return n1;
    else if (v[n2]) return n2;
    else            return cur;
  endfunction

  function automatic logic [1:0] f_lowest(input logic [2:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  function automatic logic [15:0] f_sat(input logic [15:0] x);
    return (x > 16'd9999) ? 16'd9999 : x;
  endfunction

`ifdef DISP_SCHED_ALERT_EN
  localparam int unsigned HW = (ALERT_HOLD > 1) ? $clog2(ALERT_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(ALERT_HOLD - 1);
  localparam logic [1:0] S_ALERT = 2'd2;

  logic [HW-1:0] r_hold, w_hold_nx;
  logic [15:0]   r_alert_val;
  logic          r_ack;

  assign w_accept    = i_alert_req && (r_state != S_ALERT);
  assign o_alert_ack = r_ack;
`else
  logic w_unused_alert;
  assign w_unused_alert = ^{i_alert_req, i_alert_val, ALERT_HOLD[0]};
  assign w_accept       = 1'b0;
  assign o_alert_ack    = 1'b0;
`endif

  always_comb begin
    case (r_cur)
      2'd0:    w_src_sel = i_src0_val;
      2'd1:    w_src_sel = i_src1_val;
      default: w_src_sel = i_src2_val;
    endcase
  end

  // r_cur is frozen while in ALERT, so it doubles as the saved source index.
  always_comb begin
    w_state_nx = r_state;
    w_cur_nx   = r_cur;
    w_dwell_nx = r_dwell;
`ifdef DISP_SCHED_ALERT_EN
    w_hold_nx  = r_hold;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_accept && (|i_src_valid)) begin
          w_state_nx = S_ROTATE;
          w_cur_nx   = f_lowest(i_src_valid);
          w_dwell_nx = '0;
        end
      end
      S_ROTATE: begin
        if (w_accept) begin
          w_dwell_nx = r_dwell;
        end else if (!i_src_valid[r_cur]) begin
          w_dwell_nx = '0;
          if (|i_src_valid) w_cur_nx = f_next(r_cur, i_src_valid);
          else              w_state_nx = S_IDLE;
        end else if (i_tick) begin
          if (r_dwell == DWELL_LAST) begin
            w_dwell_nx = '0;
            w_cur_nx   = f_next(r_cur, i_src_valid);
          end else begin
            w_dwell_nx = r_dwell + 1'b1;
          end
        end
      end
`ifdef DISP_SCHED_ALERT_EN
      S_ALERT: begin
        if (i_tick) begin
          if (r_hold == HOLD_LAST) begin
            w_dwell_nx = '0;
            if (|i_src_valid) begin
              w_state_nx = S_ROTATE;
              w_cur_nx   = i_src_valid[r_cur] ? r_cur : f_next(r_cur, i_src_valid);
            end else begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_hold_nx = r_hold + 1'b1;
          end
        end
      end
`endif
      default: w_state_nx = S_IDLE;
    endcase
`ifdef DISP_SCHED_ALERT_EN
    if (w_accept) begin
      w_state_nx = S_ALERT;
      w_hold_nx  = '0;
    end
`endif
  end

  always_comb begin
    w_value_nx = '0;
    w_src_nx   = '0;
    w_blank_nx = 1'b1;
    case (r_state)
      S_ROTATE: begin
        w_value_nx = f_sat(w_src_sel);
        w_src_nx   = r_cur;
        w_blank_nx = 1'b0;
      end
`ifdef DISP_SCHED_ALERT_EN
      S_ALERT: begin
        w_value_nx = f_sat(r_alert_val);
        w_src_nx   = 2'd3;
        w_blank_nx = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_dwell      <= '0;
      o_disp_value <= '0;
      o_disp_src   <= '0;
      o_disp_blank <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_cur        <= w_cur_nx;
      r_dwell      <= w_dwell_nx;
      o_disp_value <= w_value_nx;
      o_disp_src   <= w_src_nx;
      o_disp_blank <= w_blank_nx;
    end
  end

`ifdef DISP_SCHED_ALERT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold      <= '0;
      r_alert_val <= '0;
      r_ack       <= 1'b0;
    end else begin
      r_hold <= w_hold_nx;
      r_ack  <= w_accept;
      if (w_accept) r_alert_val <= i_alert_val;
    end
  end
`endif

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler (DWELL=4, ALERT_HOLD=6); alert checks follow DISP_SCHED_ALERT_EN.
module tb_display_scheduler;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic [2:0]  src_valid;
  logic [15:0] src0_val, src1_val, src2_val;
  logic        alert_req;
  logic [15:0] alert_val;
  logic        alert_ack;
  logic [15:0] disp_value;
  logic [1:0]  disp_src;
  logic        disp_blank;

  int unsigned checks = 0;
  int unsigned errors = 0;

  display_scheduler #(.DWELL(4), .ALERT_HOLD(6)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_tick       (tick),
    .i_src_valid  (src_valid),
    .i_src0_val   (src0_val),
    .i_src1_val   (src1_val),
    .i_src2_val   (src2_val),
    .i_alert_req  (alert_req),
    .i_alert_val  (alert_val),
    .o_alert_ack  (alert_ack),
    .o_disp_value (disp_value),
    .o_disp_src   (disp_src),
    .o_disp_blank (disp_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic tick_show(input string tag, input logic [1:0] esrc, input logic [15:0] eval);
    do_tick();
    cyc();
    chk({tag, "_src"}, 32'(disp_src), 32'(esrc));
    chk({tag, "_val"}, 32'(disp_value), 32'(eval));
  endtask

  logic [15:0] rot_exp [3];

  initial begin
    rst_n = 1'b0; tick = 1'b0; src_valid = '0;
    src0_val = '0; src1_val = '0; src2_val = '0;
    alert_req = 1'b0; alert_val = '0;
    rot_exp[0] = 16'd2; rot_exp[1] = 16'd3; rot_exp[2] = 16'd1;
    cyc(); cyc();
    chk("rst_value", 32'(disp_value), 0);
    chk("rst_src",   32'(disp_src), 0);
    chk("rst_blank", 32'(disp_blank), 1);
    chk("rst_ack",   32'(alert_ack), 0);
    rst_n = 1'b1;

    // Blank while nothing valid, then first source appears.
    for (int i = 0; i < 3; i++) begin do_tick(); cyc(); end
    chk("idle_blank", 32'(disp_blank), 1);
    chk("idle_value", 32'(disp_value), 0);
    src1_val = 16'd42; src_valid = 3'b010;
    cyc(); cyc();
    chk("first_src",   32'(disp_src), 1);
    chk("first_val",   32'(disp_value), 42);
    chk("first_blank", 32'(disp_blank), 0);

    // Back to IDLE, then rotate over all three.
    src_valid = 3'b000;
    cyc(); cyc();
    chk("drop_all_blank", 32'(disp_blank), 1);
    src0_val = 16'd1; src1_val = 16'd2; src2_val = 16'd3; src_valid = 3'b111;
    cyc(); cyc();
    chk("rot_start", 32'(disp_value), 1);
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 4; t++) begin
        do_tick(); cyc();
        if (t < 3) chk("rot_hold", 32'(disp_value), (r == 0) ? 32'd1 : 32'(rot_exp[r-1]));
        else       chk("rot_step", 32'(disp_value), 32'(rot_exp[r]));
      end
    end

    // Saturation on live source 0.
    src0_val = 16'hFFFF; cyc(); chk("sat_ffff", 32'(disp_value), 9999);
    src0_val = 16'd10000; cyc(); chk("sat_10000", 32'(disp_value), 9999);
    src0_val = 16'd9999; cyc(); chk("sat_9999", 32'(disp_value), 9999);
    src0_val = 16'd1234; cyc(); chk("sat_1234", 32'(disp_value), 1234);

    // Skip invalid source 1, drop source 2 mid-dwell, then drop everything.
    src0_val = 16'd5; src2_val = 16'd7; src_valid = 3'b101;
    cyc();
    for (int i = 0; i < 3; i++) tick_show("skip_hold", 2'd0, 16'd5);
    tick_show("skip_to2", 2'd2, 16'd7);
    do_tick(); cyc(); do_tick(); cyc();
    src_valid = 3'b001;
    cyc(); cyc();
    chk("drop2_src", 32'(disp_src), 0);
    chk("drop2_val", 32'(disp_value), 5);
    src_valid = 3'b101;
    for (int i = 0; i < 3; i++) tick_show("dwell_reset", 2'd0, 16'd5);
    tick_show("dwell_full", 2'd2, 16'd7);
    src_valid = 3'b000;
    cyc(); cyc();
    chk("idle_again_blank", 32'(disp_blank), 1);
    chk("idle_again_val",   32'(disp_value), 0);

    // Alert stimulus while showing source 2 with one tick already spent.
    src0_val = 16'd1; src1_val = 16'd2; src2_val = 16'd3; src_valid = 3'b111;
    cyc();
    for (int i = 0; i < 8; i++) begin do_tick(); cyc(); end
    do_tick(); cyc();
    chk("pre_alert_src", 32'(disp_src), 2);
    alert_req = 1'b1; alert_val = 16'd777; tick = 1'b1;
    cyc();
    tick = 1'b0; alert_val = 16'd555;
`ifdef DISP_SCHED_ALERT_EN
    chk("ack_pulse", 32'(alert_ack), 1);
    chk("ack_src",   32'(disp_src), 2);
    cyc();
    chk("ack_low1",  32'(alert_ack), 0);
    chk("alert_src", 32'(disp_src), 3);
    chk("alert_val", 32'(disp_value), 777);
    cyc();
    chk("ack_low2",  32'(alert_ack), 0);
    alert_req = 1'b0;
    cyc();
    alert_req = 1'b1;
    cyc();
    chk("ack_in_alert", 32'(alert_ack), 0);
    alert_req = 1'b0;
    for (int i = 0; i < 5; i++) tick_show("alert_hold", 2'd3, 16'd777);
    tick_show("alert_return", 2'd2, 16'd3);
    for (int i = 0; i < 3; i++) tick_show("return_dwell", 2'd2, 16'd3);
    tick_show("return_rot", 2'd0, 16'd1);
`else
    chk("noalert_ack0", 32'(alert_ack), 0);
    cyc();
    chk("noalert_ack1", 32'(alert_ack), 0);
    chk("noalert_src",  32'(disp_src), 2);
    chk("noalert_val",  32'(disp_value), 3);
    cyc();
    chk("noalert_ack2", 32'(alert_ack), 0);
    alert_req = 1'b0;
    tick_show("noalert_hold", 2'd2, 16'd3);
    tick_show("noalert_rot", 2'd0, 16'd1);
`endif

    // Asynchronous reset mid-dwell.
    do_tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_blank", 32'(disp_blank), 1);
    chk("async_rst_val",   32'(disp_value), 0);
    chk("async_rst_src",   32'(disp_src), 0);
    chk("async_rst_ack",   32'(alert_ack), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
